// File: rtl/gpcore_pkg.sv
// Shared core types: register address and commit-register payload.
package gpcore_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic            we;
    reg_addr_t       rd;
    logic [XLEN-1:0] result;
  } commit_t;
endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters with busy/full lookup for the issue stage.
// COMMIT_FWD_EN adds the count==1 lookups used by the commit forward path.
module wb_scoreboard
  import gpcore_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int CNT_W = 2
) (
  input  logic      clk,
  input  logic      nrst,
  input  logic      iss_valid,
  input  logic      iss_we,
  input  reg_addr_t iss_rd,
  input  reg_addr_t iss_rs1,
  input  reg_addr_t iss_rs2,
  input  logic      dec_valid,
  input  reg_addr_t dec_rd,
  output logic      busy_rs1,
  output logic      busy_rs2,
`ifdef COMMIT_FWD_EN
  output logic [1:0] single,
`endif
  output logic      sb_full
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NREGS-1:0][CNT_W-1:0] cnt;

  // x0 is never incremented, so its counter stays at zero and never reads busy.
  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    logic             inc, dec;
    logic [CNT_W-1:0] c;

    assign inc    = iss_valid && iss_we && (iss_rd == reg_addr_t'(r)) && (r != 0);
    assign dec    = dec_valid && (dec_rd == reg_addr_t'(r));
    assign cnt[r] = c;

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)                               c <= '0;
      else if (inc && !dec && c != CNT_MAX)    c <= c + 1'b1;
      else if (dec && !inc && c != '0)         c <= c - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst && dec_valid) assert (cnt[dec_rd] != '0);
  end

  assign busy_rs1 = cnt[iss_rs1] != '0;
  assign busy_rs2 = cnt[iss_rs2] != '0;
  assign sb_full  = (cnt[iss_rd] == CNT_MAX) && (iss_rd != '0);
`ifdef COMMIT_FWD_EN
  assign single   = {cnt[iss_rs2] == CNT_ONE, cnt[iss_rs1] == CNT_ONE};
`endif
endmodule

// File: rtl/commit_stage.sv
// Commit register, retired-instruction counter and RAW scoreboard front end.
// COMMIT_FWD_EN adds a commit->issue forward path that hides one stall cycle.
module commit_stage
  import gpcore_pkg::*;
#(
  parameter int XLEN      = gpcore_pkg::XLEN,
  parameter int NREGS     = 32,
  parameter int CNT_W     = 2,
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 iss_valid,
  input  logic                 iss_we,
  input  reg_addr_t            iss_rd,
  input  reg_addr_t            iss_rs1,
  input  reg_addr_t            iss_rs2,
  output logic                 busy_rs1,
  output logic                 busy_rs2,
  output logic                 sb_full,
  input  logic                 exe_valid,
  input  logic                 exe_we,
  input  reg_addr_t            exe_rd,
  input  logic [XLEN-1:0]      exe_result,
`ifdef COMMIT_FWD_EN
  output logic                 fwd_a,
  output logic                 fwd_b,
  output logic [XLEN-1:0]      fwd_a_data,
  output logic [XLEN-1:0]      fwd_b_data,
`endif
  output logic                 we_c,
  output reg_addr_t            rdaddr,
  output logic [XLEN-1:0]      wb_d,
  output logic [INSTRET_W-1:0] instret
);
  commit_t              commit_q;
  logic [INSTRET_W-1:0] instret_q;
  logic                 sb_busy1, sb_busy2;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      commit_q  <= '0;
      instret_q <= '0;
    end else begin
      commit_q.we     <= exe_valid && exe_we && (exe_rd != '0);
      commit_q.rd     <= exe_rd;
      commit_q.result <= exe_result;
      if (exe_valid) instret_q <= instret_q + 1'b1;
    end
  end

  assign we_c    = commit_q.we;
  assign rdaddr  = commit_q.rd;
  assign wb_d    = commit_q.result;
  assign instret = instret_q;

`ifdef COMMIT_FWD_EN
  logic [1:0] single;
`endif

  wb_scoreboard #(.NREGS(NREGS), .CNT_W(CNT_W)) u_sb (
    .clk       (clk),
    .nrst      (nrst),
    .iss_valid (iss_valid),
    .iss_we    (iss_we),
    .iss_rd    (iss_rd),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .dec_valid (we_c),
    .dec_rd    (rdaddr),
    .busy_rs1  (sb_busy1),
    .busy_rs2  (sb_busy2),
`ifdef COMMIT_FWD_EN
    .single    (single),
`endif
    .sb_full   (sb_full)
  );

`ifdef COMMIT_FWD_EN
  // Only the last outstanding write may be forwarded; an older one still leaves a newer pending.
  assign fwd_a      = we_c && (rdaddr == iss_rs1) && single[0];
  assign fwd_b      = we_c && (rdaddr == iss_rs2) && single[1];
  assign fwd_a_data = wb_d;
  assign fwd_b_data = wb_d;
  assign busy_rs1   = sb_busy1 && !fwd_a;
  assign busy_rs2   = sb_busy2 && !fwd_b;
`else
  assign busy_rs1   = sb_busy1;
  assign busy_rs2   = sb_busy2;
`endif
endmodule
